// File: rtl/running_extrema_tracker_pkg.sv
// running_extrema_tracker_pkg: shared state encoding and default widths
package running_extrema_tracker_pkg;
  localparam int SIZE_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;
endpackage

// File: rtl/running_extrema_tracker_cmp.sv
// running_extrema_tracker_cmp: chained unsigned magnitude comparator, MSB first
module running_extrema_tracker_cmp
  import running_extrema_tracker_pkg::*;
#(
  parameter int Size = SIZE_DEF
) (
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  output logic            g,
  output logic            l
);
  logic [Size:0] gc, lc;
  assign gc[Size] = 1'b0;
  assign lc[Size] = 1'b0;
  genvar i;
  for (i = Size - 1; i >= 0; i--) begin : g_chain
    assign gc[i] = gc[i+1] | (~lc[i+1] & a[i] & ~b[i]);
    assign lc[i] = lc[i+1] | (~gc[i+1] & ~a[i] & b[i]);
  end
  assign g = gc[0];
  assign l = lc[0];
endmodule

// File: rtl/running_extrema_tracker.sv
// running_extrema_tracker: per-frame running max/min with first indices and beat count
module running_extrema_tracker
  import running_extrema_tracker_pkg::*;
#(
  parameter int Size  = SIZE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Size-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [Size-1:0]  out_max,
  output logic [Size-1:0]  out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  state_t state, nxt;
  logic xfer, g_max, l_max, g_min, l_min, sat;
  assign in_ready  = state != OUT;
  assign out_valid = state == OUT;
  assign xfer      = in_valid & in_ready;
  assign sat       = &out_count;

  running_extrema_tracker_cmp #(.Size(Size)) u_cmp_max (.a(in_data), .b(out_max), .g(g_max), .l(l_max));
  running_extrema_tracker_cmp #(.Size(Size)) u_cmp_min (.a(in_data), .b(out_min), .g(g_min), .l(l_min));

  // A comparator can never report greater and less at the same time
  always @(posedge clk) begin
    if (!rst) assert (!(g_max && l_max) && !(g_min && l_min));
  end

  // State register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
  end

  // Next state: a record is held in OUT until downstream takes it
  always_comb begin
    nxt = state;
    nxt = (state == OUT) ? (out_ready ? IDLE : OUT) : (xfer ? (in_last ? OUT : ACCUM) : state);
  end

  // Datapath: first beat loads, later beats replace only on strict win so ties keep the earlier index
  always_ff @(posedge clk) begin
    if (rst) begin
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_count   <= '0;
      out_ovf     <= 1'b0;
    end else if (xfer && state == IDLE) begin
      out_max     <= in_data;
      out_min     <= in_data;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_count   <= CNT_W'(1);
      out_ovf     <= 1'b0;
    end else if (xfer) begin
      if (g_max) begin
        out_max     <= in_data;
        out_max_idx <= out_count;
      end
      if (l_min) begin
        out_min     <= in_data;
        out_min_idx <= out_count;
      end
      out_count <= sat ? out_count : out_count + CNT_W'(1);
      out_ovf   <= out_ovf | sat;
    end
  end
endmodule
